// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus: instruction-memory request/response plus
// the instruction valid/accept handshake toward the core.
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            ImemReq;
  logic [XLEN-1:0] ImemAddr;
  logic            ImemValid;
  logic [31:0]     ImemRdata;
  logic [31:0]     Instr;
  logic [6:0]      OpCode;
  logic [XLEN-1:0] Pc;
  logic            InstrValid;
  logic            InstrAccept;
  logic            Branch;
  logic            Zero;
  logic [XLEN-1:0] ImmB;
  logic            MisalignErr;

  modport master (
    output ImemReq,
    output ImemAddr,
    input  ImemValid,
    input  ImemRdata,
    output Instr,
    output OpCode,
    output Pc,
    output InstrValid,
    input  InstrAccept,
    input  Branch,
    input  Zero,
    input  ImmB,
    output MisalignErr
  );

  modport slave (
    input  ImemReq,
    input  ImemAddr,
    output ImemValid,
    output ImemRdata,
    input  Instr,
    input  OpCode,
    input  Pc,
    input  InstrValid,
    output InstrAccept,
    output Branch,
    output Zero,
    output ImmB,
    input  MisalignErr
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Multicycle RV32 fetch unit: FETCH -> WAIT -> ISSUE per word,
// next PC sequential or branch target, sticky misalign trap.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               rst_n,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    ISSUE,
    ERROR
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [31:0]     instr_q;
  logic [31:0]     instr_d;
  logic            valid_q;
  logic            valid_d;
  logic            req_q;
  logic            req_d;
  logic            err_q;
  logic            err_d;

  logic            accept;
  logic            fill;
  logic            taken;
  logic [XLEN-1:0] target;
  logic            misalign;

  assign accept   = (state_q == ISSUE) && bus.InstrAccept;
  assign fill     = (state_q == WAIT) && bus.ImemValid;
  assign taken    = bus.Branch & bus.Zero;
  assign target   = taken ? pc_q + bus.ImmB
                          : pc_q + XLEN'(4);
  assign misalign = |target[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  // FETCH lingers one cycle with req low after reset so the
  // registered request pulse always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: if (req_q) state_d = WAIT;
      WAIT:  if (bus.ImemValid) state_d = ISSUE;
      ISSUE: begin
        if (bus.InstrAccept)
          state_d = misalign ? ERROR : FETCH;
      end
      ERROR: state_d = ERROR;
    endcase
  end

  always_comb begin
    req_d   = (state_d == FETCH);
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    unique case (1'b1)
      fill: begin
        instr_d = bus.ImemRdata;
        valid_d = 1'b1;
      end
      accept: begin
        valid_d = 1'b0;
        if (misalign) err_d = 1'b1;
        else          pc_d  = target;
      end
      default: ;
    endcase
  end

  assign bus.ImemReq     = req_q;
  assign bus.ImemAddr    = pc_q;
  assign bus.Pc          = pc_q;
  assign bus.Instr       = instr_q;
  assign bus.OpCode      = instr_q[6:0];
  assign bus.InstrValid  = valid_q;
  assign bus.MisalignErr = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: driver pushes expected
// fetch addresses / instructions, a negedge monitor pops them.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ins_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  instr_fetch_unit_if #(.XLEN(32)) bus();

  instr_fetch_unit #(
    .XLEN(32),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_req_q[$];
  ins_t        exp_ins_q[$];
  logic [31:0] model_pc = RESET_PC;
  logic        exp_err = 1'b0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every request and every presented instruction is
  // matched against the scoreboard queues.
  initial begin
    bit   prev_valid;
    ins_t cur;
    prev_valid = 1'b0;
    cur = '{32'h0, 32'h0};
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_valid = 1'b0;
      end else begin
        if (bus.ImemReq) begin
          if (exp_req_q.size() == 0)
            chk("unexpected_req", 32'd1, 32'd0);
          else
            chk("imem_addr", bus.ImemAddr, exp_req_q.pop_front());
        end
        if (bus.InstrValid) begin
          if (!prev_valid) begin
            if (exp_ins_q.size() == 0)
              chk("unexpected_valid", 32'd1, 32'd0);
            else
              cur = exp_ins_q.pop_front();
          end
          chk("instr", bus.Instr, cur.ins);
          chk("opcode", 32'(bus.OpCode), 32'(cur.ins[6:0]));
          chk("pc", bus.Pc, cur.pc);
        end
        prev_valid = bus.InstrValid;
        chk("misalign_err", 32'(bus.MisalignErr), 32'(exp_err));
      end
    end
  end

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.ImemReq === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!got) chk("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_instr(input logic [31:0] data,
                          input int lat,
                          input int hold,
                          input bit br,
                          input bit zr,
                          input logic [31:0] imm);
    bit got;
    logic [31:0] target;
    wait_req(got);
    if (!got) return;
    // stray response in the request cycle must be dropped
    if ($urandom_range(0, 1) == 1) begin
      bus.ImemValid = 1'b1;
      bus.ImemRdata = $urandom;
    end
    for (int i = 0; i < lat; i++) begin
      @(posedge clk);
      #1;
      bus.ImemValid = 1'b0;
      bus.InstrAccept = 1'($urandom_range(0, 1));
      bus.Branch = 1'($urandom_range(0, 1));
      bus.Zero = 1'($urandom_range(0, 1));
      bus.ImmB = $urandom;
      chk("req_low_in_wait", 32'(bus.ImemReq), 32'd0);
    end
    bus.ImemValid = 1'b1;
    bus.ImemRdata = data;
    exp_ins_q.push_back('{model_pc, data});
    @(posedge clk);
    #1;
    bus.ImemValid = 1'b0;
    bus.ImemRdata = $urandom;
    bus.InstrAccept = 1'b0;
    chk("valid_latency", 32'(bus.InstrValid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      bus.Branch = 1'($urandom_range(0, 1));
      bus.Zero = 1'($urandom_range(0, 1));
      bus.ImmB = $urandom;
      bus.ImemValid = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("valid_held", 32'(bus.InstrValid), 32'd1);
    end
    bus.ImemValid = 1'b0;
    bus.Branch = br;
    bus.Zero = zr;
    bus.ImmB = imm;
    bus.InstrAccept = 1'b1;
    target = (br && zr) ? model_pc + imm : model_pc + 32'd4;
    @(posedge clk);
    #1;
    bus.InstrAccept = 1'b0;
    if (target[1:0] != 2'b00) begin
      exp_err = 1'b1;
    end else begin
      model_pc = target;
      exp_req_q.push_back(target);
    end
    chk("valid_drop", 32'(bus.InstrValid), 32'd0);
    chk("req_after_accept", 32'(bus.ImemReq), 32'(!exp_err));
  endtask

  task automatic do_reset(input bit stray);
    mon_en = 1'b0;
    rst_n = 1'b0;
    bus.ImemValid = stray;
    bus.ImemRdata = $urandom;
    bus.InstrAccept = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_req", 32'(bus.ImemReq), 32'd0);
    chk("rst_valid", 32'(bus.InstrValid), 32'd0);
    chk("rst_instr", bus.Instr, 32'd0);
    chk("rst_opcode", 32'(bus.OpCode), 32'd0);
    chk("rst_err", 32'(bus.MisalignErr), 32'd0);
    chk("rst_pc", bus.Pc, RESET_PC);
    chk("rst_addr", bus.ImemAddr, RESET_PC);
    exp_req_q.delete();
    exp_ins_q.delete();
    exp_err = 1'b0;
    model_pc = RESET_PC;
    exp_req_q.push_back(RESET_PC);
    rst_n = 1'b1;
    mon_en = 1'b1;
    if (stray) begin
      @(posedge clk);
      #1;
      chk("instr_after_stray", bus.Instr, 32'd0);
      chk("valid_after_stray", 32'(bus.InstrValid), 32'd0);
      bus.ImemValid = 1'b0;
    end
  endtask

  task automatic hold_error();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
    end
    chk("err_pc_hold", bus.Pc, model_pc);
    chk("err_addr_hold", bus.ImemAddr, model_pc);
    chk("err_no_req", 32'(bus.ImemReq), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int off;
    logic [31:0] imm;
    bus.ImemValid = 1'b0;
    bus.ImemRdata = '0;
    bus.InstrAccept = 1'b0;
    bus.Branch = 1'b0;
    bus.Zero = 1'b0;
    bus.ImmB = '0;
    @(posedge clk);
    #1;
    do_reset(1'b0);

    // sequential fetch, 1-cycle memory, immediate accept
    do_instr(32'h0020_81B3, 1, 0, 1'b0, 1'b0, 32'h0);
    do_instr(32'h0000_A103, 1, 0, 1'b0, 1'b0, 32'h0);
    do_instr(32'h0020_A023, 1, 0, 1'b0, 1'b0, 32'h0);
    do_instr($urandom, 1, 0, 1'b0, 1'b0, 32'h0);
    // at 0x10: taken -8, then branch not taken
    do_instr($urandom, 1, 0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    do_instr($urandom, 1, 0, 1'b1, 1'b0, 32'h0000_0040);
    // stalls and backpressure
    do_instr($urandom, 5, 4, 1'b0, 1'b0, 32'h0);

    // wrap-around: jump to 0xFFFFFFFC, then sequential
    do_reset(1'b0);
    do_instr($urandom, 1, 0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    do_instr($urandom, 2, 1, 1'b0, 1'b1, 32'h0);
    chk("wrap_pc", model_pc, 32'h0);

    // misaligned target from 0x20
    do_reset(1'b0);
    do_instr($urandom, 1, 0, 1'b1, 1'b1, 32'h0000_0020);
    do_instr($urandom, 2, 0, 1'b1, 1'b1, 32'h0000_0006);
    hold_error();

    // reset while in WAIT, stray responses around it
    do_reset(1'b1);
    do_instr($urandom, 1, 0, 1'b0, 1'b0, 32'h0);
    wait_req(got);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    do_reset(1'b1);
    do_instr($urandom, 1, 0, 1'b0, 1'b0, 32'h0);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      off = int'($urandom_range(0, 255)) - 128;
      imm = 32'(off * 4);
      if ($urandom_range(0, 15) == 0)
        imm = imm + 32'($urandom_range(1, 3));
      do_instr($urandom,
               int'($urandom_range(1, 4)),
               int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)),
               imm);
      if (exp_err) begin
        hold_error();
        do_reset(1'($urandom_range(0, 1)));
      end
    end

    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("ins_queue_drained", 32'(exp_ins_q.size()), 32'd0);
    chk("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
